// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier datapath.
// Used by the product deserializer, the multiplier core and the operand shifter.
package spm_pkg;

   // Default operand width and the resulting product width.
   localparam int WIDTH_DEF = 64;
   localparam int PW_DEF    = 2 * WIDTH_DEF;

   // Deserializer FSM state encoding.
   typedef logic [1:0] spm_state_t;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT    = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

endpackage

// File: rtl/product_deserializer.sv
// Collects the LSB-first serial product into a 2*WIDTH-bit register and
// offers it to the consumer with valid/ready.
//
// Handshake: p is transferred on a rising edge where valid && ready are both
// high; p is stable for as long as valid stays high, and ready while valid is
// low has no effect.
//
// Sequencing: start is sampled together with the operand load. WAIT skips the
// LAT pipeline edges of the multiplier so that the first product bit lands in
// CAPTURE. A start coinciding with the HOLD handshake begins the next capture
// immediately, giving back-to-back products with no idle cycle.
module product_deserializer
   import spm_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 bit_in,
   output logic [2*WIDTH-1:0]   p,
   output logic                 valid,
   input  logic                 ready,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   localparam int PW = 2 * WIDTH;
   localparam int BW = $clog2(PW) + 1;
   localparam int LW = $clog2(LAT + 1) + 1;

   // Terminal counts; transitions fire on equality so the counters never wrap.
   localparam logic [BW-1:0] BIT_LAST = BW'(PW - 1);
   localparam logic [LW-1:0] LAT_LAST = (LAT == 0) ? '0 : LW'(LAT - 1);

   // State to enter when a capture is launched (from IDLE or HOLD).
   localparam logic [1:0] LAUNCH = (LAT == 0) ? CAPTURE : WAIT;

   spm_state_t      state;
   spm_state_t      state_nxt;
   logic [BW-1:0]   bit_cnt;
   logic [LW-1:0]   lat_cnt;

   assign state_dbg = state;

   // Next-state selection; start outside IDLE or an accepting HOLD is ignored.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = LAUNCH;
         end
         WAIT: begin
            if (lat_cnt == LAT_LAST) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (bit_cnt == BIT_LAST) state_nxt = HOLD;
         end
         HOLD: begin
            if (valid && ready) state_nxt = start ? LAUNCH : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         p       <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         bit_cnt <= '0;
         lat_cnt <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               lat_cnt <= '0;
            end
            WAIT: begin
               lat_cnt <= lat_cnt + LW'(1);
            end
            CAPTURE: begin
               p       <= {bit_in, p[PW-1:1]};
               bit_cnt <= bit_cnt + BW'(1);
               if (bit_cnt == BIT_LAST) valid <= 1'b1;
            end
            HOLD: begin
               if (valid && ready) begin
                  valid   <= 1'b0;
                  bit_cnt <= '0;
                  lat_cnt <= '0;
               end
            end
            default: begin
               bit_cnt <= '0;
               lat_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_product_deserializer.sv
// Directed bench for product_deserializer: three instances (WIDTH=4/LAT=1,
// WIDTH=64/LAT=1, WIDTH=4/LAT=0) sharing clock and reset.
module tb_product_deserializer;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic         s4 = 0, b4 = 0, r4 = 0;
   logic [7:0]   p4;
   logic         v4, y4;
   logic [1:0]   st4;

   logic         s64 = 0, b64 = 0, r64 = 0;
   logic [127:0] p64;
   logic         v64, y64;
   logic [1:0]   st64;

   logic         s0 = 0, b0 = 0, r0 = 0;
   logic [7:0]   p0;
   logic         v0, y0;
   logic [1:0]   st0;

   product_deserializer #(.WIDTH(4), .LAT(1)) u_d4 (
      .clk(clk), .rst(rst), .start(s4), .bit_in(b4), .p(p4), .valid(v4),
      .ready(r4), .busy(y4), .state_dbg(st4));

   product_deserializer #(.WIDTH(64), .LAT(1)) u_d64 (
      .clk(clk), .rst(rst), .start(s64), .bit_in(b64), .p(p64), .valid(v64),
      .ready(r64), .busy(y64), .state_dbg(st64));

   product_deserializer #(.WIDTH(4), .LAT(0)) u_d0 (
      .clk(clk), .rst(rst), .start(s0), .bit_in(b0), .p(p0), .valid(v0),
      .ready(r0), .busy(y0), .state_dbg(st0));

   // ---------------- scoreboard ----------------
   logic [127:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive start into the WIDTH=4/LAT=1 instance and stream val LSB first.
   task automatic cap4(input logic [7:0] val);
      s4 = 1'b1;
      step();           // start edge: IDLE -> WAIT
      s4 = 1'b0;
      step();           // WAIT -> CAPTURE
      for (int i = 0; i < 8; i++) begin
         b4 = val[i];
         step();
      end
      b4 = 1'b0;
   endtask

   logic [127:0] prod64;
   logic [7:0]   t1_bits;
   int           edges;

   initial begin
      // ---------------- reset ----------------
      rst = 1'b1;
      step();
      step();
      check("rst_p4", p4, 8'h00);
      check("rst_valid4", v4, 1'b0);
      check("rst_busy4", y4, 1'b0);
      check("rst_state4", st4, S_IDLE);
      check("rst_p64", p64, 128'h0);
      rst = 1'b0;
      step();

      // ---------------- basic capture, ready held high ----------------
      r4 = 1'b1;
      t1_bits = 8'b0000_1101;   // sequence 1,0,1,1,0,0,0,0 LSB first
      exp_q.push_back(128'h0D);
      s4 = 1'b1;
      step();                   // edge 0
      s4 = 1'b0;
      check("t1_state_wait", st4, S_WAIT);
      check("t1_busy_wait", y4, 1'b1);
      step();                   // edge 1
      check("t1_state_cap", st4, S_CAPTURE);
      for (int i = 0; i < 8; i++) begin
         b4 = t1_bits[i];
         step();                // edges 2..9
         check("t1_valid_timing", v4, (i == 7));
      end
      b4 = 1'b0;
      check("t1_p", p4, exp_q.pop_front());
      check("t1_busy_hold", y4, 1'b1);
      step();                   // edge 10: accepted
      check("t1_valid_drop", v4, 1'b0);
      check("t1_busy_drop", y4, 1'b0);
      check("t1_state_idle", st4, S_IDLE);

      // ---------------- backpressure ----------------
      r4 = 1'b0;
      exp_q.push_back(128'h0D);
      cap4(8'h0D);
      check("bp_valid", v4, 1'b1);
      for (int i = 0; i < 5; i++) begin
         b4 = 1'($urandom_range(0, 1));
         s4 = (i % 2 == 0);
         step();
         check("bp_p_hold", p4, 8'h0D);
         check("bp_valid_hold", v4, 1'b1);
         check("bp_state_hold", st4, S_HOLD);
      end
      s4 = 1'b0;
      b4 = 1'b0;
      check("bp_p", p4, exp_q.pop_front());
      r4 = 1'b1;
      step();
      check("bp_valid_drop", v4, 1'b0);
      check("bp_state_idle", st4, S_IDLE);

      // ---------------- back-to-back ----------------
      r4 = 1'b0;
      exp_q.push_back(128'h0D);
      cap4(8'h0D);
      check("b2b_first_p", p4, exp_q.pop_front());
      r4 = 1'b1;
      s4 = 1'b1;
      step();                   // handshake + new start
      s4 = 1'b0;
      r4 = 1'b0;
      check("b2b_valid_drop", v4, 1'b0);
      check("b2b_state_wait", st4, S_WAIT);
      check("b2b_busy", y4, 1'b1);
      step();
      check("b2b_state_cap", st4, S_CAPTURE);
      exp_q.push_back(128'hA5);
      for (int i = 0; i < 8; i++) begin
         b4 = t1_bits[i] ^ t1_bits[i] ^ (8'hA5 >> i) & 1'b1;
         step();
      end
      b4 = 1'b0;
      check("b2b_second_valid", v4, 1'b1);
      check("b2b_second_p", p4, exp_q.pop_front());
      r4 = 1'b1;
      step();
      check("b2b_second_drop", v4, 1'b0);

      // ---------------- reset mid-capture ----------------
      r4 = 1'b0;
      s4 = 1'b1;
      step();
      s4 = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         b4 = 1'b1;
         step();
      end
      #2;
      rst = 1'b1;
      #1;
      check("mr_p", p4, 8'h00);
      check("mr_valid", v4, 1'b0);
      check("mr_busy", y4, 1'b0);
      check("mr_state", st4, S_IDLE);
      step();
      rst = 1'b0;
      b4 = 1'b0;
      step();
      exp_q.push_back(128'h3C);
      cap4(8'h3C);
      check("mr_recap_valid", v4, 1'b1);
      check("mr_recap_p", p4, exp_q.pop_front());
      r4 = 1'b1;
      step();
      r4 = 1'b0;

      // ---------------- WIDTH=64 full-scale square ----------------
      prod64 = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
      exp_q.push_back(prod64);
      s64 = 1'b1;
      step();                   // start edge k
      s64 = 1'b0;
      edges = 0;
      while (!v64 && edges < 300) begin
         edges++;
         b64 = (edges >= 2 && edges <= 129) ? prod64[edges-2] : 1'b0;
         step();                // edge k+edges
      end
      b64 = 1'b0;
      check("w64_valid_edge", 32'(edges), 32'd129);
      check("w64_p", p64, exp_q.pop_front());
      r64 = 1'b1;
      step();
      check("w64_valid_drop", v64, 1'b0);
      r64 = 1'b0;

      // ---------------- LAT=0 ----------------
      r0 = 1'b0;
      exp_q.push_back(128'hFF);
      s0 = 1'b1;
      step();                   // edge k
      s0 = 1'b0;
      check("l0_state_cap", st0, S_CAPTURE);
      for (int i = 0; i < 8; i++) begin
         b0 = 1'b1;
         s0 = (i == 3);         // ignored mid-capture
         step();                // edges k+1..k+8
         check("l0_valid_timing", v0, (i == 7));
      end
      s0 = 1'b0;
      b0 = 1'b0;
      check("l0_p", p0, exp_q.pop_front());
      check("l0_state_hold", st0, S_HOLD);
      r0 = 1'b1;
      step();
      check("l0_valid_drop", v0, 1'b0);
      check("l0_state_idle", st0, S_IDLE);

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
